// File: rtl/lcd_char_engine.sv
// lcd_char_engine: HD44780-class character LCD driver.
// Runs the power-on init sequence, then streams queued command/data bytes from a
// write FIFO to the panel with setup, enable-pulse and execution-wait timing.
// Supports an 8-bit bus or a 4-bit bus on LCD_DATA[7:4] (high nibble first).
// Optional build macro LCD_CURSOR_TRACK_EN: track the DDRAM cursor on data writes
// and insert a set-address command when a line is filled.
module lcd_char_engine #(
  parameter int unsigned BUS_4BIT       = 0,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned SETUP_CYC      = 4,
  parameter int unsigned EN_HIGH_CYC    = 25,
  parameter int unsigned SHORT_WAIT_CYC = 2000,
  parameter int unsigned LONG_WAIT_CYC  = 82000,
  parameter int unsigned INIT_WAIT_CYC  = 205000,
  parameter int unsigned POWERUP_CYC    = 750000,
  parameter int unsigned TWO_LINE       = 1
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET_N,
  input  logic                          WR_VALID,
  input  logic                          WR_RS,
  input  logic [7:0]                    WR_DATA,
  output logic                          WR_READY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          INIT_DONE,
  output logic                          BUSY,
  output logic [7:0]                    LCD_DATA,
  output logic                          LCD_RS,
  output logic                          LCD_RW,
  output logic                          LCD_EN
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned MAX_CYC = max2(max2(max2(SETUP_CYC, EN_HIGH_CYC),
                                              max2(SHORT_WAIT_CYC, LONG_WAIT_CYC)),
                                         max2(INIT_WAIT_CYC, POWERUP_CYC));
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  typedef logic [CW-1:0] cnt_t;

  // Counters are loaded with N-1 and count down to 0.
  localparam cnt_t SETUP_LD   = cnt_t'(SETUP_CYC - 1);
  localparam cnt_t ENH_LD     = cnt_t'(EN_HIGH_CYC - 1);
  localparam cnt_t SHORT_LD   = cnt_t'(SHORT_WAIT_CYC - 1);
  localparam cnt_t LONG_LD    = cnt_t'(LONG_WAIT_CYC - 1);
  localparam cnt_t INIT_LD    = cnt_t'(INIT_WAIT_CYC - 1);
  localparam cnt_t POWERUP_LD = cnt_t'(POWERUP_CYC - 1);

  localparam bit          BUS4     = (BUS_4BIT != 0);
  localparam logic [3:0]  INIT_LEN = BUS4 ? 4'd8 : 4'd7;
  localparam logic [7:0]  FSET     = (BUS4 ? 8'h20 : 8'h30) | ((TWO_LINE != 0) ? 8'h08 : 8'h00);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT_LOAD,
    ST_SETUP,
    ST_EN_HIGH,
    ST_WAIT,
    ST_IDLE
  } state_e;

  // Init table. In 4-bit mode the first four entries are single-nibble writes of
  // the high nibble only; the rest are full bytes sent as two nibbles.
  function automatic logic [7:0] init_byte(input logic [3:0] idx);
    logic [7:0] b;
    if (BUS4) begin
      case (idx)
        4'd0, 4'd1, 4'd2: b = 8'h30;
        4'd3:             b = 8'h20;
        4'd4:             b = FSET;
        4'd5:             b = 8'h0C;
        4'd6:             b = 8'h01;
        default:          b = 8'h06;
      endcase
    end else begin
      case (idx)
        4'd0, 4'd1, 4'd2: b = 8'h30;
        4'd3:             b = FSET;
        4'd4:             b = 8'h0C;
        4'd5:             b = 8'h01;
        default:          b = 8'h06;
      endcase
    end
    return b;
  endfunction

  // Clear display / return home need the long execution wait.
  function automatic logic is_long(input logic rs, input logic [7:0] d);
    return !rs && (d[7:2] == 6'd0) && (d != 8'd0);
  endfunction

  state_e      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  cnt_t        wait_q, wait_d;
  logic [3:0]  init_idx_q, init_idx_d;
  logic        init_done_q, init_done_d;
  logic [3:0]  lo_nib_q, lo_nib_d;
  logic        nib_pend_q, nib_pend_d;
  logic [7:0]  lcd_data_q, lcd_data_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic        lcd_en_q, lcd_en_d;

  // FIFO storage: {rs, data}
  logic [8:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] level_q;
  logic        fifo_empty, fifo_full, push, pop;
  logic [8:0]  fifo_head;

  // Transfer launch request, shared by init, FIFO pop and inserted commands.
  logic        launch;
  logic        l_rs;
  logic        l_two;
  logic [7:0]  l_byte;
  cnt_t        l_wait;

`ifdef LCD_CURSOR_TRACK_EN
  logic [3:0]  col_q, col_d;
  logic        line_q, line_d;
  logic        wrap_pend_q, wrap_pend_d;
`endif

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == FULL_LVL);
  assign push       = WR_VALID && !fifo_full;
  assign fifo_head  = mem_q[rd_ptr_q];

  assign WR_READY   = !fifo_full;
  assign FIFO_LEVEL = level_q;
  assign INIT_DONE  = init_done_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign LCD_DATA   = lcd_data_q;
  assign LCD_RS     = lcd_rs_q;
  assign LCD_RW     = 1'b0;
  assign LCD_EN     = lcd_en_q;

  // Next-state, counter and bus-value logic for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    lo_nib_d    = lo_nib_q;
    nib_pend_d  = nib_pend_q;
    lcd_data_d  = lcd_data_q;
    lcd_rs_d    = lcd_rs_q;
    pop         = 1'b0;
    launch      = 1'b0;
    l_rs        = 1'b0;
    l_two       = 1'b0;
    l_byte      = 8'h00;
    l_wait      = SHORT_LD;
`ifdef LCD_CURSOR_TRACK_EN
    col_d       = col_q;
    line_d      = line_q;
    wrap_pend_d = wrap_pend_q;
`endif

    case (state_q)
      ST_POWERUP: begin
        if (cnt_q == '0) state_d = ST_INIT_LOAD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_INIT_LOAD: begin
        launch     = 1'b1;
        l_byte     = init_byte(init_idx_q);
        l_two      = BUS4 && (init_idx_q >= 4'd4);
        l_wait     = (init_idx_q == 4'd0) ? INIT_LD :
                     (is_long(1'b0, l_byte) ? LONG_LD : SHORT_LD);
        init_idx_d = init_idx_q + 1'b1;
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_EN_HIGH;
          cnt_d   = ENH_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_EN_HIGH: begin
        if (cnt_q == '0) begin
          if (nib_pend_q) begin
            // Low nibble follows with its own setup; no wait between nibbles.
            nib_pend_d = 1'b0;
            lcd_data_d = {lo_nib_q, 4'h0};
            state_d    = ST_SETUP;
            cnt_d      = SETUP_LD;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = wait_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          if (init_done_q) begin
            state_d = ST_IDLE;
          end else if (init_idx_q == INIT_LEN) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_INIT_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_IDLE: begin
`ifdef LCD_CURSOR_TRACK_EN
        if (wrap_pend_q) begin
          launch      = 1'b1;
          l_byte      = line_q ? 8'hC0 : 8'h80;
          l_two       = BUS4;
          l_wait      = SHORT_LD;
          wrap_pend_d = 1'b0;
        end else
`endif
        if (!fifo_empty) begin
          pop    = 1'b1;
          launch = 1'b1;
          l_rs   = fifo_head[8];
          l_byte = fifo_head[7:0];
          l_two  = BUS4;
          l_wait = is_long(fifo_head[8], fifo_head[7:0]) ? LONG_LD : SHORT_LD;
        end
      end
      default: begin
        state_d = ST_POWERUP;
        cnt_d   = POWERUP_LD;
      end
    endcase

    // RS/DATA are latched once per transfer and held through SETUP, EN_HIGH, WAIT.
    if (launch) begin
      lo_nib_d   = l_byte[3:0];
      nib_pend_d = l_two;
      wait_d     = l_wait;
      lcd_rs_d   = l_rs;
      lcd_data_d = BUS4 ? {l_byte[7:4], 4'h0} : l_byte;
      state_d    = ST_SETUP;
      cnt_d      = SETUP_LD;
    end

`ifdef LCD_CURSOR_TRACK_EN
    if (pop) begin
      if (fifo_head[8]) begin
        if (col_q == 4'd15) begin
          col_d       = 4'd0;
          line_d      = (TWO_LINE != 0) ? ~line_q : 1'b0;
          wrap_pend_d = 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end else if (fifo_head[7:0] == 8'h01 || fifo_head[7:0] == 8'h02) begin
        col_d       = 4'd0;
        line_d      = 1'b0;
        wrap_pend_d = 1'b0;
      end else if (fifo_head[7]) begin
        col_d       = fifo_head[3:0];
        line_d      = (TWO_LINE != 0) ? fifo_head[6] : 1'b0;
        wrap_pend_d = 1'b0;
      end
    end
`endif

    lcd_en_d = (state_d == ST_EN_HIGH);
  end

  // Sequencer state and registered panel outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q     <= ST_POWERUP;
      cnt_q       <= POWERUP_LD;
      wait_q      <= '0;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
      lo_nib_q    <= '0;
      nib_pend_q  <= 1'b0;
      lcd_data_q  <= '0;
      lcd_rs_q    <= 1'b0;
      lcd_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      lo_nib_q    <= lo_nib_d;
      nib_pend_q  <= nib_pend_d;
      lcd_data_q  <= lcd_data_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_en_q    <= lcd_en_d;
    end
  end

`ifdef LCD_CURSOR_TRACK_EN
  // Cursor position tracking registers.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      col_q       <= '0;
      line_q      <= 1'b0;
      wrap_pend_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      line_q      <= line_d;
      wrap_pend_q <= wrap_pend_d;
    end
  end
`endif

  // FIFO pointers and occupancy; simultaneous push and pop keep the level.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // FIFO storage, no reset needed.
  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wr_ptr_q] <= {WR_RS, WR_DATA};
  end

endmodule

// File: tb/tb_lcd_char_engine.sv
// Self-checking bench for lcd_char_engine: an 8-bit instance driven with
// traffic and a 4-bit instance that only runs its init sequence. Every EN
// pulse is checked against a scoreboard queue of expected {rs, data}.
module tb_lcd_char_engine;

  localparam int SETUP  = 2;
  localparam int ENH    = 3;
  localparam int SHORTW = 5;
  localparam int LONGW  = 12;
  localparam int INITW  = 10;
  localparam int PWR    = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid, wr_rs;
  logic [7:0] wr_data;
  logic       wr_valid4, wr_rs4;
  logic [7:0] wr_data4;

  logic       wr_ready8, init_done8, busy8, rs8, rw8, en8;
  logic [4:0] level8;
  logic [7:0] data8;
  logic       wr_ready4, init_done4, busy4, rs4, rw4, en4;
  logic [4:0] level4;
  logic [7:0] data4;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [8:0] exp8_q[$];
  logic [8:0] exp4_q[$];
  bit         mon_chk = 1'b1;

  always #5 clk = ~clk;

  lcd_char_engine #(
    .BUS_4BIT(0), .FIFO_DEPTH(16), .SETUP_CYC(SETUP), .EN_HIGH_CYC(ENH),
    .SHORT_WAIT_CYC(SHORTW), .LONG_WAIT_CYC(LONGW), .INIT_WAIT_CYC(INITW),
    .POWERUP_CYC(PWR), .TWO_LINE(1)
  ) dut8 (
    .CLOCK_50(clk), .RESET_N(rst_n), .WR_VALID(wr_valid), .WR_RS(wr_rs),
    .WR_DATA(wr_data), .WR_READY(wr_ready8), .FIFO_LEVEL(level8),
    .INIT_DONE(init_done8), .BUSY(busy8), .LCD_DATA(data8), .LCD_RS(rs8),
    .LCD_RW(rw8), .LCD_EN(en8)
  );

  lcd_char_engine #(
    .BUS_4BIT(1), .FIFO_DEPTH(16), .SETUP_CYC(SETUP), .EN_HIGH_CYC(ENH),
    .SHORT_WAIT_CYC(SHORTW), .LONG_WAIT_CYC(LONGW), .INIT_WAIT_CYC(INITW),
    .POWERUP_CYC(PWR), .TWO_LINE(1)
  ) dut4 (
    .CLOCK_50(clk), .RESET_N(rst_n), .WR_VALID(wr_valid4), .WR_RS(wr_rs4),
    .WR_DATA(wr_data4), .WR_READY(wr_ready4), .FIFO_LEVEL(level4),
    .INIT_DONE(init_done4), .BUSY(busy4), .LCD_DATA(data4), .LCD_RS(rs4),
    .LCD_RW(rw4), .LCD_EN(en4)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the 8-bit instance.
  logic en8_prev = 1'b0;
  int   w8 = 0;
  always @(negedge clk) begin
    if (en8 && !en8_prev) begin
      if (exp8_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL dut8 unexpected EN pulse: got 0x%0h, want none", {rs8, data8});
      end else begin
        check("dut8 bus {rs,data}", {rs8, data8}, exp8_q.pop_front());
      end
      check("dut8 RW", rw8, 0);
      w8 <= 1;
    end else if (en8) begin
      w8 <= w8 + 1;
    end else if (en8_prev && mon_chk) begin
      check("dut8 EN width", w8, ENH);
    end
    en8_prev <= en8;
  end

  // Scoreboard monitor for the 4-bit instance.
  logic en4_prev = 1'b0;
  int   w4 = 0;
  always @(negedge clk) begin
    if (en4 && !en4_prev) begin
      if (exp4_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL dut4 unexpected EN pulse: got 0x%0h, want none", {rs4, data4});
      end else begin
        check("dut4 bus {rs,data}", {rs4, data4}, exp4_q.pop_front());
      end
      w4 <= 1;
    end else if (en4) begin
      w4 <= w4 + 1;
    end else if (en4_prev && mon_chk) begin
      check("dut4 EN width", w4, ENH);
    end
    en4_prev <= en4;
  end

  task automatic load_init();
    exp8_q.delete();
    exp4_q.delete();
    exp8_q = '{9'h030, 9'h030, 9'h030, 9'h038, 9'h00C, 9'h001, 9'h006};
    exp4_q = '{9'h030, 9'h030, 9'h030, 9'h020, 9'h020, 9'h080,
               9'h000, 9'h0C0, 9'h000, 9'h010, 9'h000, 9'h060};
  endtask

  // Release reset at a negedge; count edges from the first edge that samples it high.
  task automatic release_and_time_first_en();
    int cyc;
    rst_n = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
      if (en8) break;
    end
    check("first EN latency after reset", cyc, 22);
  endtask

  task automatic wait_init_and_drain(input int exp8_left);
    bit s8 = 1'b0;
    bit s4 = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (!s8 && init_done8) begin
        s8 = 1'b1;
        check("dut8 init pulses seen at INIT_DONE", exp8_q.size(), exp8_left);
      end
      if (!s4 && init_done4) begin
        s4 = 1'b1;
        check("dut4 BUSY at INIT_DONE", busy4, 0);
      end
      if (s8 && s4 && !busy8 && level8 == 5'd0) break;
    end
    check("dut8 INIT_DONE seen", s8, 1);
    check("dut4 INIT_DONE seen", s4, 1);
    check("dut8 idle after drain", busy8, 0);
    check("dut8 FIFO_LEVEL after drain", level8, 0);
    check("dut8 WR_READY after drain", wr_ready8, 1);
    check("dut8 scoreboard empty", exp8_q.size(), 0);
    check("dut4 scoreboard empty", exp4_q.size(), 0);
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         busy_cyc;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int model_lvl;
    int cyc;

    // IDLE + SETUP + EN + wait: short = 11, long = 18.
    vecs[0] = '{1'b1, 8'h41, 11};
    vecs[1] = '{1'b0, 8'h01, 18};
    vecs[2] = '{1'b0, 8'h0C, 11};
    vecs[3] = '{1'b0, 8'h02, 18};
    vecs[4] = '{1'b0, 8'h03, 18};
    vecs[5] = '{1'b1, 8'h01, 11};
    vecs[6] = '{1'b0, 8'h00, 11};
    vecs[7] = '{1'b0, 8'h04, 11};
    vecs[8] = '{1'b0, 8'h80, 11};

    rst_n     = 1'b0;
    wr_valid  = 1'b0;
    wr_rs     = 1'b0;
    wr_data   = 8'h00;
    wr_valid4 = 1'b0;
    wr_rs4    = 1'b0;
    wr_data4  = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset LCD_EN", en8, 0);
    check("reset LCD_RS", rs8, 0);
    check("reset LCD_RW", rw8, 0);
    check("reset LCD_DATA", data8, 0);
    check("reset INIT_DONE", init_done8, 0);
    check("reset BUSY", busy8, 1);
    check("reset FIFO_LEVEL", level8, 0);
    check("reset WR_READY", wr_ready8, 1);
    check("reset dut4 LCD_EN", en4, 0);
    check("reset dut4 BUSY", busy4, 1);

    load_init();
    release_and_time_first_en();

    // Fill the FIFO during init; the 17th push must be dropped.
    model_lvl = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check($sformatf("WR_READY before push %0d", i), wr_ready8, (model_lvl < 16) ? 1 : 0);
      wr_valid = 1'b1;
      wr_rs    = i[0];
      wr_data  = 8'(8'h50 + i);
      if (model_lvl < 16) begin
        exp8_q.push_back({wr_rs, wr_data});
        model_lvl++;
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    check("FIFO_LEVEL when full", level8, 16);
    check("WR_READY when full", wr_ready8, 0);
    check("INIT_DONE still low while filling", init_done8, 0);

    wait_init_and_drain(16);

    // Table-driven single transfers: bus value checked by the scoreboard,
    // BUSY-return latency checked here.
    foreach (vecs[k]) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_rs    = vecs[k].rs;
      wr_data  = vecs[k].data;
      exp8_q.push_back({vecs[k].rs, vecs[k].data});
      @(posedge clk);
      @(negedge clk);
      wr_valid = 1'b0;
      cyc = 0;
      do begin
        @(posedge clk);
        cyc++;
        @(negedge clk);
      end while (busy8 && cyc < 100);
      check($sformatf("BUSY latency vec %0d (rs=%0d data=0x%0h)", k, vecs[k].rs, vecs[k].data),
            cyc, vecs[k].busy_cyc);
    end
    check("dut8 scoreboard empty after table", exp8_q.size(), 0);

    // Reset while EN is high, with one entry still queued.
    @(negedge clk);
    wr_valid = 1'b1;
    wr_rs    = 1'b1;
    wr_data  = 8'h55;
    exp8_q.push_back(9'h155);
    @(negedge clk);
    wr_rs    = 1'b0;
    wr_data  = 8'h0C;
    exp8_q.push_back(9'h00C);
    @(negedge clk);
    wr_valid = 1'b0;
    for (int c = 0; c < 100 && !en8; c++) @(negedge clk);
    check("EN high before abort", en8, 1);
    check("FIFO_LEVEL before abort", level8, 1);
    mon_chk = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort LCD_EN", en8, 0);
    check("abort INIT_DONE", init_done8, 0);
    check("abort FIFO_LEVEL", level8, 0);
    check("abort BUSY", busy8, 1);
    check("abort WR_READY", wr_ready8, 1);
    load_init();
    @(negedge clk);
    mon_chk = 1'b1;
    release_and_time_first_en();
    wait_init_and_drain(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
